// File: rtl/mult32x32_share_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : mult_arb_pkg                                                   |
// | Shared types and widths for the two-port multiplier share arbiter:       |
// |   arb_state_t - scheduler state encoding                                 |
// |   REQ_ID_W    - width of the requester id (two requesters)               |
// |   OPERAND_W   - multiplier operand width                                 |
// |   PRODUCT_W   - multiplier product width                                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package mult_arb_pkg;

  localparam int REQ_ID_W  = 1;
  localparam int OPERAND_W = 32;
  localparam int PRODUCT_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // arbitrate between requesters
    ST_START = 3'd1,  // start pulse is on the wire
    ST_WAIT  = 3'd2,  // waiting for the multiplier to raise busy
    ST_RUN   = 3'd3,  // waiting for the multiplier to drop busy
    ST_RESP  = 3'd4   // response held until consumed
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mult32x32_share_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : mult32x32_share_arb_if                                       |
// | Bundles the two request/response ports and the multiplier handshake.     |
// |   req0/1_valid, req0/1_a, req0/1_b, req0/1_ready : request ports         |
// |   rsp0/1_valid, rsp0/1_ready, rsp_product, rsp_err : response ports      |
// |   mult_start, mult_a, mult_b, mult_busy, mult_product : multiplier side  |
// | Modports: slave  = the arbiter                                           |
// |           master = clients plus multiplier surrounding the arbiter       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface mult32x32_share_arb_if;
  import mult_arb_pkg::*;

  logic                 req0_valid;
  logic                 req1_valid;
  logic [OPERAND_W-1:0] req0_a;
  logic [OPERAND_W-1:0] req0_b;
  logic [OPERAND_W-1:0] req1_a;
  logic [OPERAND_W-1:0] req1_b;
  logic                 req0_ready;
  logic                 req1_ready;

  logic                 rsp0_valid;
  logic                 rsp1_valid;
  logic                 rsp0_ready;
  logic                 rsp1_ready;
  logic [PRODUCT_W-1:0] rsp_product;
  logic                 rsp_err;

  logic                 mult_start;
  logic [OPERAND_W-1:0] mult_a;
  logic [OPERAND_W-1:0] mult_b;
  logic                 mult_busy;
  logic [PRODUCT_W-1:0] mult_product;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, mult_busy, mult_product,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_product, rsp_err, mult_start, mult_a, mult_b
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, mult_busy, mult_product,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_product, rsp_err, mult_start, mult_a, mult_b
  );

endinterface
`default_nettype wire

// File: rtl/mult32x32_share_arb_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : rr_arb2                                                         |
// | Two-way round-robin grant with a priority pointer register.              |
// |   clk, reset  : clock, synchronous active-high reset                     |
// |   req_valid   : pending request per requester                          |
// |   xfer        : a transfer happened on the current grant                 |
// |   grant_valid : some requester is granted                                |
// |   grant_id    : id of the granted requester                              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module rr_arb2
  import mult_arb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  input  logic                xfer,
  output logic                grant_valid,
  output logic [REQ_ID_W-1:0] grant_id
);

  // prio_q holds the id favoured on contention; reset favours requester 0.
  logic [REQ_ID_W-1:0] prio_q;
  logic [REQ_ID_W-1:0] prio_d;

  always_comb begin
    grant_valid = |req_valid;
    grant_id    = '0;
    if (&req_valid) begin
      grant_id = prio_q;
    end else if (req_valid[1]) begin
      grant_id = 1'b1;
    end
    // Favour the requester that was not just served.
    prio_d = prio_q;
    if (xfer) begin
      prio_d = ~grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= '0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult32x32_share_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : mult32x32_share_arb                                             |
// | Round-robin scheduler sharing one 32x32 multiplier between two clients.  |
// | Captures operands, drives the start/busy handshake, holds operands       |
// | stable and returns each product (or a timeout error) to its requester.   |
// |   clk, reset : clock, synchronous active-high reset                      |
// |   bus        : request, response and multiplier signals (slave modport)  |
// | Parameter TIMEOUT_CYCLES (6..255): start-to-done limit before abort.     |
// | Optional macro MULT_ARB_ZERO_BYPASS_EN: a zero operand answers 0 at once |
// | without using the multiplier.                                            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mult32x32_share_arb
  import mult_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8
)(
  input  logic           clk,
  input  logic           reset,
  mult32x32_share_arb_if.slave bus
);

  // Counter is zero in the first WAIT cycle, so the abort decision is taken
  // when it holds TIMEOUT_CYCLES-1 to land the error TIMEOUT_CYCLES+2 after
  // the transfer.
  localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t           state_q,       state_d;
  logic [REQ_ID_W-1:0]  grant_id_q,    grant_id_d;
  logic [OPERAND_W-1:0] mult_a_q,      mult_a_d;
  logic [OPERAND_W-1:0] mult_b_q,      mult_b_d;
  logic                 mult_start_q,  mult_start_d;
  logic [7:0]           cnt_q,         cnt_d;
  logic [PRODUCT_W-1:0] rsp_product_q, rsp_product_d;
  logic                 rsp_err_q,     rsp_err_d;
  logic                 rsp0_valid_q,  rsp0_valid_d;
  logic                 rsp1_valid_q,  rsp1_valid_d;

  logic                 grant_valid;
  logic [REQ_ID_W-1:0]  grant_id;
  logic                 xfer;
  logic [OPERAND_W-1:0] sel_a;
  logic [OPERAND_W-1:0] sel_b;
  logic                 rsp_ack;
  logic                 timeout_hit;

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .reset       (reset),
    .req_valid   ({bus.req1_valid, bus.req0_valid}),
    .xfer        (xfer),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Ready is offered only in IDLE and never while reset is asserted, so a
  // request presented during reset is not falsely acknowledged.
  assign xfer           = (state_q == ST_IDLE) && !reset && grant_valid;
  assign bus.req0_ready = xfer && (grant_id == 1'b0);
  assign bus.req1_ready = xfer && (grant_id == 1'b1);

  assign sel_a       = (grant_id == 1'b1) ? bus.req1_a : bus.req0_a;
  assign sel_b       = (grant_id == 1'b1) ? bus.req1_b : bus.req0_b;
  assign rsp_ack     = (grant_id_q == 1'b1) ? bus.rsp1_ready : bus.rsp0_ready;
  assign timeout_hit = (cnt_q == C_TIMEOUT_LAST);

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    mult_a_d      = mult_a_q;
    mult_b_d      = mult_b_q;
    mult_start_d  = 1'b0;
    cnt_d         = cnt_q;
    rsp_product_d = rsp_product_q;
    rsp_err_d     = rsp_err_q;
    rsp0_valid_d  = rsp0_valid_q;
    rsp1_valid_d  = rsp1_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          grant_id_d = grant_id;
          mult_a_d   = sel_a;
          mult_b_d   = sel_b;
`ifdef MULT_ARB_ZERO_BYPASS_EN
          if ((sel_a == '0) || (sel_b == '0)) begin
            state_d       = ST_RESP;
            rsp_product_d = '0;
            rsp_err_d     = 1'b0;
            rsp0_valid_d  = (grant_id == 1'b0);
            rsp1_valid_d  = (grant_id == 1'b1);
          end else begin
            state_d      = ST_START;
            mult_start_d = 1'b1;
          end
`else
          state_d      = ST_START;
          mult_start_d = 1'b1;
`endif
        end
      end

      ST_START: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (timeout_hit) begin
          state_d       = ST_RESP;
          rsp_product_d = '0;
          rsp_err_d     = 1'b1;
          rsp0_valid_d  = (grant_id_q == 1'b0);
          rsp1_valid_d  = (grant_id_q == 1'b1);
        end else if (bus.mult_busy) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q + 8'd1;
        // A completion seen in the same cycle as the limit still wins.
        if (!bus.mult_busy) begin
          state_d       = ST_RESP;
          rsp_product_d = bus.mult_product;
          rsp_err_d     = 1'b0;
          rsp0_valid_d  = (grant_id_q == 1'b0);
          rsp1_valid_d  = (grant_id_q == 1'b1);
        end else if (timeout_hit) begin
          state_d       = ST_RESP;
          rsp_product_d = '0;
          rsp_err_d     = 1'b1;
          rsp0_valid_d  = (grant_id_q == 1'b0);
          rsp1_valid_d  = (grant_id_q == 1'b1);
        end
      end

      ST_RESP: begin
        // Only the owning requester's ready releases the response.
        if (rsp_ack) begin
          state_d      = ST_IDLE;
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_id_q    <= '0;
      mult_a_q      <= '0;
      mult_b_q      <= '0;
      mult_start_q  <= 1'b0;
      cnt_q         <= '0;
      rsp_product_q <= '0;
      rsp_err_q     <= 1'b0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      mult_a_q      <= mult_a_d;
      mult_b_q      <= mult_b_d;
      mult_start_q  <= mult_start_d;
      cnt_q         <= cnt_d;
      rsp_product_q <= rsp_product_d;
      rsp_err_q     <= rsp_err_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
    end
  end

  assign bus.mult_start  = mult_start_q;
  assign bus.mult_a      = mult_a_q;
  assign bus.mult_b      = mult_b_q;
  assign bus.rsp_product = rsp_product_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp1_valid  = rsp1_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mult32x32_share_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_mult32x32_share_arb                                          |
// | Directed self-checking bench for mult32x32_share_arb with a stub         |
// | multiplier whose busy length is 1 + (a MSW!=0) + 2*(b MSW!=0) cycles.    |
// | Build with or without MULT_ARB_ZERO_BYPASS_EN.                           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mult32x32_share_arb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult32x32_share_arb_if bus();

  mult32x32_share_arb #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_err = 0;
  int n_chk = 0;

  // ---------------- stub multiplier ----------------
  logic        stuck = 1'b0;
  int unsigned rem;

  function automatic int unsigned busy_len(input logic [31:0] a, input logic [31:0] b);
    return 1 + ((a[31:16] != 16'd0) ? 1 : 0) + ((b[31:16] != 16'd0) ? 2 : 0);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      bus.mult_busy    <= 1'b0;
      bus.mult_product <= 64'd0;
      rem              <= 0;
    end else if (bus.mult_start && !stuck) begin
      bus.mult_busy <= 1'b1;
      rem           <= busy_len(bus.mult_a, bus.mult_b);
    end else if (bus.mult_busy) begin
      if (rem == 1) begin
        bus.mult_busy    <= 1'b0;
        bus.mult_product <= {32'd0, bus.mult_a} * {32'd0, bus.mult_b};
      end
      rem <= rem - 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request, wait for its transfer (T0) and for its response.
  // lat counts cycles from T0 to the cycle rsp valid is seen.
  task automatic issue(input int port, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int starts, output int other);
    int w;
    if (port == 0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
    end
    #1;
    w = 0;
    while (!((port == 0) ? bus.req0_ready : bus.req1_ready) && w < 20) begin
      step;
      w++;
    end
    chk("xfer_ready", {63'd0, (port == 0) ? bus.req0_ready : bus.req1_ready}, 64'd1);
    step;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    lat = 1; starts = 0; other = 0;
    while (!((port == 0) ? bus.rsp0_valid : bus.rsp1_valid) && lat < 30) begin
      starts += int'(bus.mult_start);
      other  += int'((port == 0) ? bus.rsp1_valid : bus.rsp0_valid);
      step;
      lat++;
    end
  endtask

  task automatic consume(input int port);
    if (port == 0) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
    step;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat, starts, other, blocked, seen, nresp, cyc;
    int g[$];

    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    repeat (2) step;
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd0);
    chk("rst_rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd0);
    chk("rst_product", bus.rsp_product, 64'd0);
    chk("rst_err", {63'd0, bus.rsp_err}, 64'd0);
    chk("rst_start", {63'd0, bus.mult_start}, 64'd0);
    chk("rst_mult_a", {32'd0, bus.mult_a}, 64'd0);
    chk("rst_mult_b", {32'd0, bus.mult_b}, 64'd0);

    // Single request: 3*5, k=1 -> 4 cycles
    issue(0, 32'h0000_0003, 32'h0000_0005, lat, starts, other);
    chk("single_lat", 64'(lat), 64'd4);
    chk("single_starts", 64'(starts), 64'd1);
    chk("single_product", bus.rsp_product, 64'd15);
    chk("single_err", {63'd0, bus.rsp_err}, 64'd0);
    chk("single_other", 64'(other) + {63'd0, bus.rsp1_valid}, 64'd0);
    consume(0);

    // Full width on req1: k=4 -> 7 cycles
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, starts, other);
    chk("full_lat", 64'(lat), 64'd7);
    chk("full_product", bus.rsp_product, 64'hFFFF_FFFE_0000_0001);
    chk("full_err", {63'd0, bus.rsp_err}, 64'd0);
    chk("full_rsp0_quiet", 64'(other) + {63'd0, bus.rsp0_valid}, 64'd0);
    consume(1);

    // Contention with both responses always ready
    bus.req0_a = 32'h0000_0010; bus.req0_b = 32'h0000_0020;  // 0x200
    bus.req1_a = 32'h0001_0000; bus.req1_b = 32'h0000_0003;  // 0x30000
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    nresp = 0; cyc = 0;
    while (nresp < 4 && cyc < 200) begin
      bus.req0_valid = (g.size() < 4);
      bus.req1_valid = (g.size() < 4);
      #1;
      if (bus.req0_ready) g.push_back(0);
      else if (bus.req1_ready) g.push_back(1);
      if (bus.rsp0_valid) begin
        chk("cont_p0", bus.rsp_product, 64'h200);
        nresp++;
      end
      if (bus.rsp1_valid) begin
        chk("cont_p1", bus.rsp_product, 64'h3_0000);
        nresp++;
      end
      step;
      cyc++;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    chk("cont_nresp", 64'(nresp), 64'd4);
    chk("cont_ngrant", 64'(g.size()), 64'd4);
    for (int i = 0; i < g.size(); i++) chk("cont_grant_order", 64'(g[i]), 64'(i % 2));

    // Backpressure on rsp0 while req1 waits
    step;
    bus.req0_a = 32'd7; bus.req0_b = 32'd9; bus.req1_a = 32'd2; bus.req1_b = 32'd3;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    chk("bp_grant0", {63'd0, bus.req0_ready}, 64'd1);
    chk("bp_req1_blocked_t0", {63'd0, bus.req1_ready}, 64'd0);
    step;
    bus.req0_valid = 1'b0;
    #1;
    lat = 1; blocked = 0;
    while (!bus.rsp0_valid && lat < 30) begin
      blocked += int'(bus.req1_ready);
      step;
      lat++;
    end
    chk("bp_lat", 64'(lat), 64'd4);
    bus.rsp1_ready = 1'b1;  // must be ignored: response belongs to req0
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", {63'd0, bus.rsp0_valid}, 64'd1);
      chk("bp_hold_product", bus.rsp_product, 64'd63);
      blocked += int'(bus.req1_ready);
      step;
    end
    bus.rsp1_ready = 1'b0;
    bus.rsp0_ready = 1'b1;
    #1;
    blocked += int'(bus.req1_ready);
    chk("bp_req1_blocked", 64'(blocked), 64'd0);
    step;
    bus.rsp0_ready = 1'b0;
    #1;
    chk("bp_req1_ready_after", {63'd0, bus.req1_ready}, 64'd1);
    chk("bp_rsp0_dropped", {63'd0, bus.rsp0_valid}, 64'd0);
    step;
    bus.req1_valid = 1'b0;
    #1;
    lat = 1;
    while (!bus.rsp1_valid && lat < 30) begin
      step;
      lat++;
    end
    chk("bp_req1_lat", 64'(lat), 64'd4);
    chk("bp_req1_product", bus.rsp_product, 64'd6);
    consume(1);

    // Timeout: busy never rises -> error 10 cycles after T0
    stuck = 1'b1;
    issue(0, 32'd4, 32'd5, lat, starts, other);
    chk("to_lat", 64'(lat), 64'd10);
    chk("to_err", {63'd0, bus.rsp_err}, 64'd1);
    chk("to_product", bus.rsp_product, 64'd0);
    consume(0);
    stuck = 1'b0;
    issue(1, 32'd6, 32'd7, lat, starts, other);
    chk("after_to_lat", 64'(lat), 64'd4);
    chk("after_to_product", bus.rsp_product, 64'd42);
    chk("after_to_err", {63'd0, bus.rsp_err}, 64'd0);
    consume(1);

    // Reset while in RUN (k=4: WAIT at T2, RUN at T3)
    bus.req0_a = 32'h0002_0000; bus.req0_b = 32'h0003_0000; bus.req0_valid = 1'b1;
    #1;
    chk("rr_xfer", {63'd0, bus.req0_ready}, 64'd1);
    step;                      // T1
    bus.req0_valid = 1'b0;
    step;                      // T2
    step;                      // T3
    reset = 1'b1;
    step;                      // T4
    reset = 1'b0;
    #1;
    chk("rr_mult_a", {32'd0, bus.mult_a}, 64'd0);
    chk("rr_mult_b", {32'd0, bus.mult_b}, 64'd0);
    chk("rr_product", bus.rsp_product, 64'd0);
    chk("rr_start", {63'd0, bus.mult_start}, 64'd0);
    chk("rr_valids", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      seen += int'(bus.rsp0_valid) + int'(bus.mult_start);
      step;
    end
    chk("rr_no_response", 64'(seen), 64'd0);

    // Zero operand
    issue(0, 32'd0, 32'd9, lat, starts, other);
`ifdef MULT_ARB_ZERO_BYPASS_EN
    chk("zero_lat", 64'(lat), 64'd1);
    chk("zero_starts", 64'(starts), 64'd0);
`else
    chk("zero_lat", 64'(lat), 64'd4);
    chk("zero_starts", 64'(starts), 64'd1);
`endif
    chk("zero_product", bus.rsp_product, 64'd0);
    chk("zero_err", {63'd0, bus.rsp_err}, 64'd0);
    consume(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
